// File: rtl/shifter_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: op codes, FSM
// state encoding and the shift-amount width helper.
package shifter_pkg;

  localparam logic [2:0] SRL_SRLI = 3'b001;
  localparam logic [2:0] SLL_SLLI = 3'b011;
  localparam logic [2:0] SRA_SRAI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of the shift amount / remaining count for a given operand width.
  function automatic int amt_width(input int opd_length);
    return $clog2(opd_length);
  endfunction

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == SRL_SRLI) || (op == SLL_SLLI) || (op == SRA_SRAI);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One iteration of the sequencer's shift: moves data by BIG_STEP or by 1
// according to the op. SRA keeps the sign bit of the incoming data.
module shift_step
  import shifter_pkg::*;
#(
  parameter int OPD_LENGTH = 32,
  parameter int BIG_STEP   = 4
) (
  input  logic [OPD_LENGTH-1:0] data,
  input  logic [2:0]            op,
  input  logic                  sel_big,
  output logic [OPD_LENGTH-1:0] result
);

  always_comb begin
    result = data;
    case (op)
      SRL_SRLI: result = sel_big ? (data >> BIG_STEP) : (data >> 1);
      SLL_SLLI: result = sel_big ? (data << BIG_STEP) : (data << 1);
      SRA_SRAI: result = sel_big ? ($signed(data) >>> BIG_STEP)
                                 : ($signed(data) >>> 1);
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SRL/SLL/SRA controller: accepts one op per handshake, shifts
// by BIG_STEP or 1 per cycle, and holds the result until it is consumed.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | ready for a request, result registers hold last value
//   ST_SHIFT | iterating; remaining count decremented every cycle
//   ST_DONE  | result_valid high, waiting for result_ready
module shift_sequencer
  import shifter_pkg::*;
#(
  parameter int OPD_LENGTH = 32,
  parameter int BIG_STEP   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [OPD_LENGTH-1:0] opd1,
  input  logic [OPD_LENGTH-1:0] opd2,
  input  logic [3:0]            alu_op_select,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [OPD_LENGTH-1:0] shifter_result,
  output logic                  op_error,
  output logic                  busy
);

  localparam int AMT_W = amt_width(OPD_LENGTH);
  localparam logic [AMT_W-1:0] BIG_AMT = AMT_W'(BIG_STEP);
  localparam logic [AMT_W-1:0] ONE_AMT = AMT_W'(1);

  state_t                  state_q, state_d;
  logic [OPD_LENGTH-1:0]   data_q, data_d;
  logic [AMT_W-1:0]        count_q, count_d;
  logic [2:0]              op_q, op_d;
  logic                    err_q, err_d;

  logic                    sel_big;
  logic [AMT_W-1:0]        count_next;
  logic [OPD_LENGTH-1:0]   step_data;
  logic [AMT_W-1:0]        req_amt;
  logic [2:0]              req_op;
  logic                    req_ok;

  // Upper amount bits and op bit 3 are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{opd2[OPD_LENGTH-1:AMT_W], alu_op_select[3]};

  assign req_amt    = opd2[AMT_W-1:0];
  assign req_op     = alu_op_select[2:0];
  assign req_ok     = op_is_valid(req_op);
  assign sel_big    = (count_q >= BIG_AMT);
  assign count_next = sel_big ? (count_q - BIG_AMT) : (count_q - ONE_AMT);

  shift_step #(
    .OPD_LENGTH (OPD_LENGTH),
    .BIG_STEP   (BIG_STEP)
  ) u_step (
    .data    (data_q),
    .op      (op_q),
    .sel_big (sel_big),
    .result  (step_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    count_d      = count_q;
    op_d         = op_q;
    err_d        = err_q;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          data_d  = req_ok ? opd1 : '0;
          count_d = req_amt;
          op_d    = req_op;
          err_d   = !req_ok;
          state_d = (req_ok && (req_amt != '0)) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        data_d  = step_data;
        count_d = count_next;
        if (count_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign shifter_result = data_q;
  assign op_error       = err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a cycle-level behavioural model (result from
// plain shift arithmetic, latency from the step-count formula) checked every
// cycle, plus directed operations with hand-computed results and latencies.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] opd1;
  logic [31:0] opd2;
  logic [3:0]  alu_op_select;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] shifter_result;
  logic        op_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.OPD_LENGTH(32), .BIG_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .opd1           (opd1),
    .opd2           (opd2),
    .alu_op_select  (alu_op_select),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .shifter_result (shifter_result),
    .op_error       (op_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted op becomes "busy" and turns valid after
  // n/4 + n%4 further cycles (zero for n==0 or an invalid op).
  logic        live = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_res = '0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    int n;
    if (rst) begin
      live    = 1'b1;
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_cnt   = 0;
    end else if (!m_busy) begin
      if (start_valid) begin
        n     = int'(opd2 % 32);
        m_err = 1'b0;
        case (alu_op_select[2:0])
          3'b001:  m_res = opd1 >> n;
          3'b011:  m_res = opd1 << n;
          3'b111:  m_res = $signed(opd1) >>> n;
          default: begin m_res = '0; m_err = 1'b1; end
        endcase
        m_cnt   = m_err ? 0 : (n / 4 + n % 4);
        m_busy  = 1'b1;
        m_valid = (m_cnt == 0);
      end
    end else if (m_valid) begin
      if (result_ready) begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_start_ready", 32'(start_ready), 32'(!m_busy));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_result_valid", 32'(result_valid), 32'(m_valid));
      if (m_valid) begin
        chk("model_result", shifter_result, m_res);
        chk("model_op_error", 32'(op_error), 32'(m_err));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_op_error"}, 32'(op_error), 32'd0);
    chk({tag, "_result"}, shifter_result, 32'd0);
  endtask

  // Issue one op from IDLE, measure latency, check the literal result, then
  // optionally hold result_ready low for `hold` cycles with a pending request.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] n, input logic [31:0] exp_res,
                        input logic exp_err, input int exp_lat, input int hold);
    int lat;
    chk({name, "_idle_before"}, 32'(start_ready), 32'd1);
    start_valid   = 1'b1;
    alu_op_select = op;
    opd1          = a;
    opd2          = n;
    @(negedge clk);
    start_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_result"}, shifter_result, exp_res);
    chk({name, "_op_error"}, 32'(op_error), 32'(exp_err));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        start_valid   = 1'b1;
        alu_op_select = 4'b0011;
        opd1          = 32'h0000_00FF;
        opd2          = 32'd1;
        @(negedge clk);
        chk({name, "_bp_result"}, shifter_result, exp_res);
        chk({name, "_bp_valid"}, 32'(result_valid), 32'd1);
        chk({name, "_bp_start_ready"}, 32'(start_ready), 32'd0);
      end
      start_valid = 1'b0;
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({name, "_ready_after"}, 32'(start_ready), 32'd1);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_result_hold"}, shifter_result, exp_res);
  endtask

  initial begin
    rst           = 1'b1;
    start_valid   = 1'b0;
    result_ready  = 1'b0;
    opd1          = '0;
    opd2          = '0;
    alu_op_select = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op("srl31",   4'b0001, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 11, 0);
    run_op("sra4",    4'b0111, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0, 2,  0);
    run_op("sll5",    4'b0011, 32'h0000_0001, 32'd5,  32'h0000_0020, 1'b0, 3,  0);
    run_op("sll0",    4'b0011, 32'h1234_5678, 32'd0,  32'h1234_5678, 1'b0, 1,  0);
    run_op("sll32",   4'b0011, 32'h1234_5678, 32'd32, 32'h1234_5678, 1'b0, 1,  0);
    run_op("badop",   4'b0101, 32'hDEAD_BEEF, 32'd3,  32'h0000_0000, 1'b1, 1,  0);
    run_op("srl33b3", 4'b1001, 32'h0000_00F0, 32'd33, 32'h0000_0078, 1'b0, 2,  0);
    run_op("sra7",    4'b0111, 32'h8000_0000, 32'd7,  32'hFF00_0000, 1'b0, 5,  0);
    run_op("bp_sra6", 4'b0111, 32'h8000_0000, 32'd6,  32'hFE00_0000, 1'b0, 4,  5);

    // Reset in the middle of SRA 0x80000000 by 20.
    start_valid   = 1'b1;
    alu_op_select = 4'b0111;
    opd1          = 32'h8000_0000;
    opd2          = 32'd20;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_mid_no_result", 32'(result_valid), 32'd0);
    end

    run_op("after_rst", 4'b0001, 32'h0000_1234, 32'd8, 32'h0000_0012, 1'b0, 3, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that executes SRL/SLL/SRA operations on a small per-cycle shift step instead of a full barrel shifter, for area-constrained ALU builds. Accepts one operation per valid/ready handshake, latches operands, iterates the shift over several cycles, and holds the result until the consumer accepts it. Sits between the ALU issue logic and the ALU result mux, in place of the combinational shifter.

## Interface
Parameters:
- OPD_LENGTH, 32, operand/result width; power of two, ≥ 8
- BIG_STEP, 4, coarse shift distance per cycle; power of two, 2 ≤ BIG_STEP < OPD_LENGTH

Ports:
- clk  input  1  clock. One clock; reset is synchronous and active-high.
- rst  input  1  synchronous active-high reset
- start_valid  input  1  operation request
- start_ready  output  1  block can accept a request
- opd1  input  OPD_LENGTH  value to shift
- opd2  input  OPD_LENGTH  shift amount; only bits [log2(OPD_LENGTH)-1:0] are used
- alu_op_select  input  4  bits [2:0]: 001 SRL, 011 SLL, 111 SRA; bit 3 ignored
- result_valid  output  1  result available
- result_ready  input  1  consumer accepts result
- shifter_result  output  OPD_LENGTH  shifted value
- op_error  output  1  qualifies result_valid: op code was not one of the three valid codes
- busy  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid, latch opd1 into the data register, opd2[log2(OPD_LENGTH)-1:0] into the remaining-count register, and the op code.
  - Next state is SHIFT if count≠0 and the op is valid, else DONE.
- Invalid op: data register loads 0 and op_error sets; goes straight to DONE. No shift cycles.
- SHIFT, once per cycle:
  - if remaining ≥ BIG_STEP, shift by BIG_STEP and remaining -= BIG_STEP;
  - else shift by 1 and remaining -= 1.
  - When the updated remaining is 0, next state is DONE.
- Shift rules:
  - SRL fills with 0.
  - SLL fills with 0.
  - SRA fills with the latched opd1 MSB, which is preserved every step. This is a true arithmetic shift.
- DONE:
  - result_valid=1; shifter_result and op_error are stable.
  - On result_ready go to IDLE; otherwise hold indefinitely.
- start_ready is 0 outside IDLE. Requests during SHIFT/DONE are not accepted and not queued.
- op_error clears on the next accepted request.

## Timing
- Reset values: state IDLE; start_ready=1, result_valid=0, busy=0, op_error=0, shifter_result=0, internal count=0.
- Reset mid-operation: the in-flight op is discarded with no result; the block is in IDLE the cycle after rst.
- Acceptance edge T (IDLE & start_valid). Shift amount n, with k = n/BIG_STEP + n%BIG_STEP steps. result_valid rises k+1 cycles after T.
  - n=0 or invalid op: 1 cycle.
  - OPD_LENGTH=32, BIG_STEP=4, n=31: k=10, so 11 cycles.
- Result handshake at edge R (DONE & result_ready): IDLE from R+1, so start_ready=1 in the cycle after R.
  - Minimum one-cycle bubble between ops.
  - A new request may be presented in that cycle.
- Amounts wrap modulo OPD_LENGTH: opd2=32 behaves as 0; opd2=33 behaves as 1.
- shifter_result is only meaningful while result_valid=1. It holds its last value after leaving DONE until the next load.

## Structure
- Package shifter_pkg holds:
  - op code localparams SRL_SRLI=3'b001, SLL_SLLI=3'b011, SRA_SRAI=3'b111;
  - the state encoding (IDLE/SHIFT/DONE);
  - the clog2-derived amount width.
- Sub-module shift_step: combinational, inputs data, op, and sel_big. Output is data shifted by BIG_STEP or by 1 according to the op rules. One instance.
- The top level holds the FSM, the data/count/op registers, and the handshake logic.

## Test plan
- Reset, then SRL with opd1=0x80000000, opd2=31. Expect shifter_result=0x00000001, op_error=0, result_valid 11 cycles after acceptance.
- SRA with opd1=0xF0000000, opd2=4. Expect 0xFF000000, result_valid 2 cycles after acceptance. Then SLL with opd1=0x00000001, opd2=5. Expect 0x00000020 after 3 cycles.
- opd2=0 and opd2=32 with SLL on 0x12345678. Both return 0x12345678 after 1 cycle.
- alu_op_select=4'b0101. Expect op_error=1, shifter_result=0, result_valid after 1 cycle. A following valid op clears op_error.
- Backpressure: hold result_ready=0 for 5 cycles in DONE. Expect result held stable, start_ready=0 with start_valid=1, and no second acceptance. Release result_ready: start_ready=1 on the next cycle.
- Assert rst during SHIFT of SRA 0x80000000 by 20. Expect IDLE next cycle, all outputs at reset values, and no result_valid pulse.
